// File: rtl/ram128_pkg.sv
// Shared types and constants for the 128x32 SRAM sequencer/arbiter.
package ram128_pkg;

  typedef enum logic {INIT, RUN} state_e;
  typedef enum logic {PORT_A, PORT_B} port_e;

  localparam int unsigned RAM_DEPTH  = 128;
  localparam int unsigned BYTE_LANES = 4;
  localparam logic [BYTE_LANES-1:0] WE_FULL = 4'hF;

endpackage

// File: rtl/ram128_rr_arb.sv
// Two-way round-robin arbiter; the pointer only moves when both ports contend.
module ram128_rr_arb
  import ram128_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_en,
  input  logic  i_req_a,
  input  logic  i_req_b,
  output logic  o_gnt_a,
  output logic  o_gnt_b,
  output port_e o_winner
);

  port_e r_ptr;
  port_e w_winner;

  always_comb begin
    w_winner = PORT_A;
    if (i_req_a && i_req_b) begin
      w_winner = r_ptr;
    end else if (i_req_b) begin
      w_winner = PORT_B;
    end
  end

  assign o_winner = w_winner;
  assign o_gnt_a  = i_en & i_req_a & (w_winner == PORT_A);
  assign o_gnt_b  = i_en & i_req_b & (w_winner == PORT_B);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= PORT_A;
    end else if (i_en && i_req_a && i_req_b) begin
      r_ptr <= (w_winner == PORT_A) ? PORT_B : PORT_A;
    end
  end

endmodule

// File: rtl/ram128_arbiter.sv
// Zero-fill sequencer plus round-robin front end for a single-port 128x32 SRAM
// with registered read and byte write enables.
module ram128_arbiter
  import ram128_pkg::*;
#(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  a_req,
  input  logic [ADDR_W-1:0]     a_addr,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_W-1:0]     a_rdata,
  input  logic                  b_req,
  input  logic [DATA_W/8-1:0]   b_we,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  init_done,
  output logic                  ram_en,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [DATA_W/8-1:0]   ram_we,
  input  logic [DATA_W-1:0]     ram_rdata
);

  state_e              r_state;
  state_e              w_state_d;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_tag_vld;
  port_e               r_tag_port;
  logic                w_run;
  logic                w_init;
  logic                w_gnt_a;
  logic                w_gnt_b;
  port_e               w_winner;

  // Outputs are forced to their reset values while RST is high, so a response
  // already tagged when reset arrives is never presented.
  assign w_run  = (r_state == RUN) && !RST;
  assign w_init = (r_state == INIT) && !RST;

  ram128_rr_arb u_arb (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_en     (w_run),
    .i_req_a  (a_req),
    .i_req_b  (b_req),
    .o_gnt_a  (w_gnt_a),
    .o_gnt_b  (w_gnt_b),
    .o_winner (w_winner)
  );

  always_comb begin
    w_state_d = r_state;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = r_addr;
    ram_wdata = r_wdata;
    if (w_init) begin
      ram_en    = 1'b1;
      ram_we    = '1;
      ram_addr  = r_cnt;
      ram_wdata = '0;
      if (r_cnt == '1) begin
        w_state_d = RUN;
      end
    end else if (w_gnt_a) begin
      ram_en   = 1'b1;
      ram_addr = a_addr;
    end else if (w_gnt_b) begin
      ram_en    = 1'b1;
      ram_we    = b_we;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= (INIT_ZERO != 0) ? INIT : RUN;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tag_vld  <= 1'b0;
      r_tag_port <= PORT_A;
    end else begin
      r_state <= w_state_d;
      if (w_init) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
      // Idle cycles keep presenting the last address/data to the macro.
      if (ram_en) begin
        r_addr  <= ram_addr;
        r_wdata <= ram_wdata;
      end
      r_tag_vld  <= w_gnt_a | (w_gnt_b & (b_we == '0));
      r_tag_port <= w_winner;
    end
  end

  assign init_done = w_run;
  assign a_gnt     = w_gnt_a;
  assign b_gnt     = w_gnt_b;
  assign a_rvalid  = r_tag_vld && (r_tag_port == PORT_A) && !RST;
  assign b_rvalid  = r_tag_vld && (r_tag_port == PORT_B) && !RST;
  assign a_rdata   = a_rvalid ? ram_rdata : '0;
  assign b_rdata   = b_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram128_arbiter.sv
// Directed bench for ram128_arbiter: zero-fill, table-driven arbitration and
// read/write vectors, reset corner cases, and the INIT_ZERO=0 variant.
module tb_ram128_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        a_req, b_req;
  logic [6:0]  a_addr, b_addr;
  logic [3:0]  b_we;
  logic [31:0] b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, init_done, ram_en;
  logic [31:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
  logic [6:0]  ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] mem [128];

  logic        z_rst, z_a_req, z_b_req;
  logic [6:0]  z_a_addr, z_b_addr;
  logic [3:0]  z_b_we;
  logic [31:0] z_b_wdata;
  logic        z_a_gnt, z_a_rvalid, z_b_gnt, z_b_rvalid, z_init_done, z_ram_en;
  logic [31:0] z_a_rdata, z_b_rdata, z_ram_wdata;
  logic [31:0] z_ram_rdata = 32'h0;
  logic [6:0]  z_ram_addr;
  logic [3:0]  z_ram_we;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  ram128_arbiter #(.ADDR_W(7), .DATA_W(32), .INIT_ZERO(1)) dut (
    .CLK(CLK), .RST(RST),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata), .init_done(init_done), .ram_en(ram_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  ram128_arbiter #(.ADDR_W(7), .DATA_W(32), .INIT_ZERO(0)) dut_noinit (
    .CLK(CLK), .RST(z_rst),
    .a_req(z_a_req), .a_addr(z_a_addr), .a_gnt(z_a_gnt), .a_rvalid(z_a_rvalid),
    .a_rdata(z_a_rdata), .b_req(z_b_req), .b_we(z_b_we), .b_addr(z_b_addr),
    .b_wdata(z_b_wdata), .b_gnt(z_b_gnt), .b_rvalid(z_b_rvalid), .b_rdata(z_b_rdata),
    .init_done(z_init_done), .ram_en(z_ram_en), .ram_addr(z_ram_addr),
    .ram_wdata(z_ram_wdata), .ram_we(z_ram_we), .ram_rdata(z_ram_rdata)
  );

  // Behavioural SRAM macro: registered read, byte-lane write.
  always @(posedge CLK) begin
    if (ram_en) begin
      if (ram_we == 4'h0) begin
        ram_rdata <= mem[ram_addr];
      end else begin
        for (int l = 0; l < 4; l++) begin
          if (ram_we[l]) mem[ram_addr][l*8 +: 8] <= ram_wdata[l*8 +: 8];
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        a_req;
    logic [6:0]  a_addr;
    logic        b_req;
    logic [3:0]  b_we;
    logic [6:0]  b_addr;
    logic [31:0] b_wdata;
    logic [1:0]  gnt;      // {a_gnt, b_gnt}
    logic        en;
    logic [3:0]  we;
    logic [6:0]  addr;
    logic        a_rv;
    logic [31:0] a_rd;
    logic        b_rv;
    logic [31:0] b_rd;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // Memory starts non-zero so zero-fill is observable.
    for (int i = 0; i < 128; i++) mem[i] = 32'hA5A5_0000 | i;
    ram_rdata = 32'h0;
    RST = 1'b1; a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_we = '0; b_addr = '0;
    b_wdata = '0;
    z_rst = 1'b1; z_a_req = 1'b0; z_a_addr = '0; z_b_req = 1'b0; z_b_we = '0;
    z_b_addr = '0; z_b_wdata = '0;

    vecs[0]  = '{0, 0, 1, 4'hF, 10, 32'hDEADBEEF, 2'b01, 1, 4'hF, 10, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 4'h2, 10, 32'h0000AA00, 2'b01, 1, 4'h2, 10, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 4'h0, 10, 32'h0,        2'b01, 1, 4'h0, 10, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 4'h0, 0,  32'h0,        2'b00, 0, 4'h0, 10, 0, 0, 1, 32'hDEADAAEF};
    vecs[4]  = '{0, 0, 1, 4'hF, 0,  32'h11111111, 2'b01, 1, 4'hF, 0,  0, 0, 0, 0};
    vecs[5]  = '{0, 0, 1, 4'hF, 1,  32'h22222222, 2'b01, 1, 4'hF, 1,  0, 0, 0, 0};
    vecs[6]  = '{0, 0, 1, 4'hF, 2,  32'h33333333, 2'b01, 1, 4'hF, 2,  0, 0, 0, 0};
    vecs[7]  = '{0, 0, 1, 4'hF, 3,  32'h44444444, 2'b01, 1, 4'hF, 3,  0, 0, 0, 0};
    vecs[8]  = '{1, 0, 1, 4'h0, 1,  32'h0,        2'b10, 1, 4'h0, 0,  0, 0, 0, 0};
    vecs[9]  = '{1, 2, 1, 4'h0, 1,  32'h0,        2'b01, 1, 4'h0, 1,  1, 32'h11111111, 0, 0};
    vecs[10] = '{1, 2, 1, 4'h0, 3,  32'h0,        2'b10, 1, 4'h0, 2,  0, 0, 1, 32'h22222222};
    vecs[11] = '{1, 0, 1, 4'h0, 3,  32'h0,        2'b01, 1, 4'h0, 3,  1, 32'h33333333, 0, 0};
    vecs[12] = '{1, 0, 0, 4'h0, 0,  32'h0,        2'b10, 1, 4'h0, 0,  0, 0, 1, 32'h44444444};
    vecs[13] = '{1, 1, 0, 4'h0, 0,  32'h0,        2'b10, 1, 4'h0, 1,  1, 32'h11111111, 0, 0};
    vecs[14] = '{1, 2, 0, 4'h0, 0,  32'h0,        2'b10, 1, 4'h0, 2,  1, 32'h22222222, 0, 0};
    vecs[15] = '{1, 3, 0, 4'h0, 0,  32'h0,        2'b10, 1, 4'h0, 3,  1, 32'h33333333, 0, 0};
    vecs[16] = '{0, 0, 0, 4'h0, 0,  32'h0,        2'b00, 0, 4'h0, 3,  1, 32'h44444444, 0, 0};
    vecs[17] = '{0, 0, 1, 4'h9, 2,  32'hAABBCCDD, 2'b01, 1, 4'h9, 2,  0, 0, 0, 0};
    vecs[18] = '{0, 0, 1, 4'h0, 2,  32'h0,        2'b01, 1, 4'h0, 2,  0, 0, 0, 0};
    vecs[19] = '{0, 0, 0, 4'h0, 0,  32'h0,        2'b00, 0, 4'h0, 2,  0, 0, 1, 32'hAA3333DD};

    // Reset state.
    next_cycle();
    @(negedge CLK);
    check("reset_outputs", {a_gnt, b_gnt, a_rvalid, b_rvalid, init_done, ram_en, ram_we},
          10'h0);
    check("reset_rdata", {a_rdata, b_rdata}, 64'h0);

    // Zero-fill: 128 write cycles with a_req pending and never granted.
    next_cycle();
    RST = 1'b0; a_req = 1'b1; a_addr = 7'd5;
    for (int i = 0; i < 128; i++) begin
      @(negedge CLK);
      check($sformatf("init_cyc%0d", i),
            {a_gnt, init_done, ram_en, ram_we, 1'b0, ram_addr, ram_wdata},
            {1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 7'(i), 32'h0});
      next_cycle();
    end
    @(negedge CLK);
    check("run_first_cycle", {init_done, a_gnt, b_gnt, ram_en, ram_we, 1'b0, ram_addr},
          {1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 8'd5});
    next_cycle();
    a_req = 1'b0;
    @(negedge CLK);
    check("zero_read_addr5", {a_rvalid, a_rdata}, {1'b1, 32'h0});

    // Table-driven run-phase vectors, one cycle each.
    for (int v = 0; v < 20; v++) begin
      next_cycle();
      a_req = vecs[v].a_req; a_addr = vecs[v].a_addr; b_req = vecs[v].b_req;
      b_we = vecs[v].b_we; b_addr = vecs[v].b_addr; b_wdata = vecs[v].b_wdata;
      @(negedge CLK);
      check($sformatf("vec%0d_access", v), {a_gnt, b_gnt, ram_en, ram_we, 1'b0, ram_addr},
            {vecs[v].gnt, vecs[v].en, vecs[v].we, 1'b0, vecs[v].addr});
      check($sformatf("vec%0d_a_resp", v), {a_rvalid, a_rdata}, {vecs[v].a_rv, vecs[v].a_rd});
      check($sformatf("vec%0d_b_resp", v), {b_rvalid, b_rdata}, {vecs[v].b_rv, vecs[v].b_rd});
      if (vecs[v].we != 4'h0) check($sformatf("vec%0d_wdata", v), ram_wdata, vecs[v].b_wdata);
    end

    // Reset lands on the cycle after an A read grant: response is dropped.
    next_cycle();
    a_req = 1'b1; a_addr = 7'd1; b_req = 1'b0; b_we = '0;
    @(negedge CLK);
    check("pre_reset_gnt", {a_gnt, ram_en}, 2'b11);
    next_cycle();
    RST = 1'b1;
    @(negedge CLK);
    check("reset_drops_rvalid", {a_rvalid, a_rdata, a_gnt, ram_en}, 35'h0);
    next_cycle();
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check($sformatf("reinit_cyc%0d", i), {init_done, a_gnt, a_rvalid, ram_en, ram_we,
            1'b0, ram_addr}, {3'b000, 1'b1, 4'hF, 1'b0, 7'(i)});
      next_cycle();
    end
    // Reset in the middle of zero-fill restarts the counter.
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    check("midinit_restart", {init_done, ram_en, ram_we, 1'b0, ram_addr},
          {1'b0, 1'b1, 4'hF, 8'd0});

    // INIT_ZERO=0: first cycle after reset is already RUN.
    next_cycle();
    z_b_req = 1'b1; z_b_addr = 7'd7;
    @(negedge CLK);
    check("noinit_in_reset", {z_init_done, z_b_gnt, z_ram_en}, 3'b000);
    next_cycle();
    z_rst = 1'b0;
    @(negedge CLK);
    check("noinit_first_run", {z_init_done, z_b_gnt, z_ram_en, 1'b0, z_ram_addr},
          {3'b111, 8'd7});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram128_arbiter.md
Name: ram128_arbiter

Overview:
- Two-port sequencer and arbiter in front of one single-port 128x32 SRAM macro (registered read, 4-bit byte write enable).
- Port A is a read-only instruction-fetch requester. Port B is a read/write data requester with byte strobes.
- After reset the block optionally zero-fills the macro, then arbitrates the two ports round-robin at up to one RAM access per cycle.
- It sits between the core's fetch/LSU logic and the SRAM instance.

Parameters:
- ADDR_W, 7, word address width (128 words).
- DATA_W, 32, data width; byte lanes = DATA_W/8.
- INIT_ZERO, 1, 1 = zero-fill all words after reset before serving requests; 0 = go straight to RUN.

Ports:
- CLK  in  1  single clock for block and macro.
- RST  in  1  reset, synchronous, active-high.
- a_req  in  1  port A read request; held stable until a_gnt.
- a_addr  in  ADDR_W  port A word address.
- a_gnt  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DATA_W  port A read data.
- b_req  in  1  port B request; held stable until b_gnt.
- b_we  in  4  port B byte write mask; 4'h0 = read.
- b_addr  in  ADDR_W  port B word address.
- b_wdata  in  DATA_W  port B write data.
- b_gnt  out  1  port B request accepted this cycle.
- b_rvalid  out  1  port B read data valid (reads only).
- b_rdata  out  DATA_W  port B read data.
- init_done  out  1  high once the block is in RUN.
- ram_en  out  1  to macro EN0.
- ram_addr  out  ADDR_W  to macro A0.
- ram_wdata  out  DATA_W  to macro Di0.
- ram_we  out  4  to macro WE0.
- ram_rdata  in  DATA_W  from macro Do0; valid the cycle after an enabled read.

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- Reset values: a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, ram_en=0, ram_we=0, init_done=0, rr pointer=A, init counter=0. Any read response in flight is discarded.
- States: INIT, RUN.
  - Reset enters INIT if INIT_ZERO=1, otherwise RUN.
- INIT:
  - Each cycle: ram_en=1, ram_we=4'hF, ram_wdata=0, ram_addr=counter; then counter+1.
  - After the write at address 127, go to RUN next cycle. Zero-fill is exactly 128 cycles.
  - a_gnt=b_gnt=0 throughout. init_done rises on the first RUN cycle.
  - RST asserted mid-INIT restarts the counter at 0.
- RUN arbitration is combinational in the same cycle:
  - Only a_req: grant A.
  - Only b_req: grant B.
  - Both: grant the port named by the rr pointer, then point rr at the other port. rr updates only on contention.
  - Neither: ram_en=0, ram_we=0, ram_addr/ram_wdata hold their last values.
- Granted access, driven combinationally to the macro in the grant cycle:
  - ram_en=1; ram_addr=winner address.
  - A: ram_we=0.
  - B: ram_we=b_we, ram_wdata=b_wdata.
  - At most one gnt is high per cycle.
- Read response latency is 1 cycle:
  - A registered tag records the winner and whether the access was a read.
  - Next cycle, the matching rvalid=1 and that port's rdata=ram_rdata.
  - Non-matching rdata is 0. A B write produces no rvalid.
- Back-to-back grants every cycle are allowed. A response and a new grant may coincide.
- A write then a read to the same address in consecutive cycles returns the written data, as the macro provides.
- A request dropped before gnt is a requester protocol error; behaviour is unspecified.

Decomposition:
- Shared package ram128_pkg holds: state enum {INIT, RUN}; port-id enum {PORT_A, PORT_B}; constants RAM_DEPTH=128, BYTE_LANES=4, WE_FULL=4'hF.
- One sub-module is natural: ram128_rr_arb (2-way round-robin grant plus pointer register), instantiated once.

Test Plan:
- INIT_ZERO=1: release RST, hold a_req=1 -> ram_we=4'hF for 128 cycles at addresses 0..127, a_gnt=0 throughout, init_done=1 and a_gnt=1 on cycle 129. Then read addr 5 -> a_rdata=0.
- B writes 32'hDEADBEEF to addr 10 with b_we=4'hF, then B writes b_we=4'b0010, wdata 32'h0000AA00 -> subsequent read of 10 gives b_rvalid=1 one cycle after b_gnt, b_rdata=32'hDEADAAEF.
- a_req and b_req both held high for 4 cycles, rr=A after reset -> grants A,B,A,B. Each port's rvalid follows its gnt by 1 cycle, with no cross-delivery of data.
- A-only reads of addresses 0..3 on consecutive cycles -> a_gnt=1 every cycle, a_rvalid=1 for 4 consecutive cycles offset by 1, data in address order.
- Assert RST for 1 cycle in the cycle after an A read grant -> a_rvalid stays 0 and the controller re-enters INIT at counter 0.
- INIT_ZERO=0: release RST with b_req=1 -> init_done=1 and b_gnt=1 in the first cycle after reset.
